// File: rtl/pulse_sequencer.sv
// Programmable multi-phase pulse pattern sequencer: steps through enabled phases,
// each driving an 8-bit pattern for a programmed duration, for a set number of passes.
module pulse_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int DUR_W      = 32,
    parameter int CNT_W      = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NUM_PHASES*DUR_W-1:0] phase_dur,
    input  logic [NUM_PHASES*8-1:0]     phase_pat,
    input  logic [NUM_PHASES-1:0]       phase_en,
    input  logic [CNT_W-1:0]            repeat_cnt,
    input  logic [7:0]                  idle_pat,
    output logic [7:0]                  signal_out,
    output logic                        busy,
    output logic                        done,
    output logic [2:0]                  phase_idx,
    output logic [CNT_W-1:0]            pass_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                      state;
    logic [NUM_PHASES*DUR_W-1:0] dur_q;
    logic [NUM_PHASES*8-1:0]     pat_q;
    logic [NUM_PHASES-1:0]       en_q;
    logic [CNT_W-1:0]            rep_q;
    logic [DUR_W-1:0]            timer;

    logic [2:0]       start_phase;
    logic [2:0]       wrap_phase;
    logic [2:0]       next_phase;
    logic [2:0]       target_phase;
    logic             has_next;
    logic [DUR_W-1:0] cur_dur;
    logic [7:0]       start_pat;
    logic [7:0]       next_pat;
    logic             phase_end;
    logic [CNT_W-1:0] pass_inc;
    logic             last_pass;

    // phase_idx doubles as the current-phase pointer while running.
    always_comb begin
        start_phase  = '0;
        wrap_phase   = '0;
        next_phase   = '0;
        has_next     = 1'b0;
        cur_dur      = '0;
        start_pat    = '0;
        next_pat     = '0;
        // Descending scan so the lowest qualifying index is the one kept.
        for (int unsigned i = NUM_PHASES; i > 0; i--) begin
            if (phase_en[i-1])
                start_phase = 3'(i - 1);
            if (en_q[i-1]) begin
                wrap_phase = 3'(i - 1);
                if (3'(i - 1) > phase_idx) begin
                    next_phase = 3'(i - 1);
                    has_next   = 1'b1;
                end
            end
        end
        target_phase = has_next ? next_phase : wrap_phase;
        for (int unsigned i = 0; i < NUM_PHASES; i++) begin
            if (3'(i) == phase_idx)
                cur_dur = dur_q[i*DUR_W +: DUR_W];
            if (3'(i) == target_phase)
                next_pat = pat_q[i*8 +: 8];
            if (3'(i) == start_phase)
                start_pat = phase_pat[i*8 +: 8];
        end
    end

    // A zero duration behaves as one cycle.
    assign phase_end = (cur_dur == '0) || (timer >= cur_dur - DUR_ONE);
    assign pass_inc  = (pass_cnt == '1) ? pass_cnt : pass_cnt + CNT_ONE;
    assign last_pass = (rep_q != '0) && (pass_inc == rep_q);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            dur_q      <= '0;
            pat_q      <= '0;
            en_q       <= '0;
            rep_q      <= '0;
            timer      <= '0;
            signal_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            phase_idx  <= '0;
            pass_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    phase_idx  <= '0;
                    timer      <= '0;
                    signal_out <= idle_pat;
                    if (start && !abort) begin
                        if (phase_en != '0) begin
                            dur_q      <= phase_dur;
                            pat_q      <= phase_pat;
                            en_q       <= phase_en;
                            rep_q      <= repeat_cnt;
                            state      <= RUN;
                            busy       <= 1'b1;
                            signal_out <= start_pat;
                            phase_idx  <= start_phase;
                            pass_cnt   <= '0;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        signal_out <= idle_pat;
                        phase_idx  <= '0;
                        timer      <= '0;
                    end else if (phase_end) begin
                        timer <= '0;
                        if (has_next) begin
                            phase_idx  <= next_phase;
                            signal_out <= next_pat;
                        end else begin
                            pass_cnt <= pass_inc;
                            if (last_pass) begin
                                state      <= FIN;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                signal_out <= idle_pat;
                                phase_idx  <= '0;
                            end else begin
                                phase_idx  <= wrap_phase;
                                signal_out <= next_pat;
                            end
                        end
                    end else begin
                        timer <= timer + DUR_ONE;
                    end
                end
                FIN: begin
                    state      <= IDLE;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    phase_idx  <= '0;
                    signal_out <= idle_pat;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: vector table for short runs plus
// hand-written sequences for long runs, collisions, abort and reset.
module tb_pulse_sequencer;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [NP*DW-1:0] phase_dur;
    logic [NP*8-1:0]  phase_pat;
    logic [NP-1:0]    phase_en;
    logic [CW-1:0]    repeat_cnt;
    logic [7:0]       idle_pat;
    logic [7:0]       signal_out;
    logic             busy;
    logic             done;
    logic [2:0]       phase_idx;
    logic [CW-1:0]    pass_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pulse_sequencer #(.NUM_PHASES(NP), .DUR_W(DW), .CNT_W(CW)) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .start     (start),
        .abort     (abort),
        .phase_dur (phase_dur),
        .phase_pat (phase_pat),
        .phase_en  (phase_en),
        .repeat_cnt(repeat_cnt),
        .idle_pat  (idle_pat),
        .signal_out(signal_out),
        .busy      (busy),
        .done      (done),
        .phase_idx (phase_idx),
        .pass_cnt  (pass_cnt)
    );

    typedef struct {
        logic        start;
        logic        abort;
        logic [3:0]  en;
        logic [7:0]  idle;
        logic [7:0]  e_out;
        logic        e_busy;
        logic        e_done;
        logic [2:0]  e_idx;
        logic        chk_pass;
        logic [15:0] e_pass;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_phase(input int i, input logic [31:0] d, input logic [7:0] p);
        phase_dur[i*DW +: DW] = d;
        phase_pat[i*8 +: 8]   = p;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic [7:0] o, input logic b,
                              input logic d, input logic [2:0] ix);
        check({tag, "_out"},  32'(signal_out), 32'(o));
        check({tag, "_busy"}, 32'(busy),       32'(b));
        check({tag, "_done"}, 32'(done),       32'(d));
        check({tag, "_idx"},  32'(phase_idx),  32'(ix));
    endtask

    initial begin
        int bad;
        int first_bad;
        int busy_cycles;
        logic [7:0] eo;
        logic       eb;
        logic       ed;
        logic [2:0] ei;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        phase_dur = '0; phase_pat = '0; phase_en = '0;
        repeat_cnt = '0; idle_pat = 8'h5A;

        // Outputs must be zero during reset even though clocks run and idle_pat is nonzero.
        #17;
        check_outs("reset", 8'h00, 1'b0, 1'b0, 3'd0);
        check("reset_pass", 32'(pass_cnt), 32'd0);

        // Table run: en=1010, dur1=0, dur3=5, repeat=1, then collision vectors.
        set_phase(0, 32'd9, 8'hB0); set_phase(1, 32'd0, 8'hA1);
        set_phase(2, 32'd9, 8'hB2); set_phase(3, 32'd5, 8'hC3);
        repeat_cnt = 16'd1;
        vecs[0]  = '{1'b0, 1'b0, 4'b1010, 8'h5A, 8'h5A, 1'b0, 1'b0, 3'd0, 1'b1, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 4'b1010, 8'h3C, 8'h3C, 1'b0, 1'b0, 3'd0, 1'b1, 16'd0};
        vecs[2]  = '{1'b1, 1'b0, 4'b1010, 8'h3C, 8'hA1, 1'b1, 1'b0, 3'd1, 1'b1, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 4'b1010, 8'h3C, 8'hC3, 1'b1, 1'b0, 3'd3, 1'b1, 16'd0};
        vecs[4]  = '{1'b0, 1'b0, 4'b1111, 8'h3C, 8'hC3, 1'b1, 1'b0, 3'd3, 1'b1, 16'd0};
        vecs[5]  = '{1'b0, 1'b0, 4'b1111, 8'h3C, 8'hC3, 1'b1, 1'b0, 3'd3, 1'b1, 16'd0};
        vecs[6]  = '{1'b0, 1'b0, 4'b1010, 8'h3C, 8'hC3, 1'b1, 1'b0, 3'd3, 1'b1, 16'd0};
        vecs[7]  = '{1'b0, 1'b0, 4'b1010, 8'h3C, 8'hC3, 1'b1, 1'b0, 3'd3, 1'b1, 16'd0};
        vecs[8]  = '{1'b0, 1'b0, 4'b1010, 8'h3C, 8'h3C, 1'b0, 1'b1, 3'd0, 1'b1, 16'd1};
        vecs[9]  = '{1'b0, 1'b0, 4'b1010, 8'h3C, 8'h3C, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0};
        vecs[10] = '{1'b1, 1'b1, 4'b1010, 8'h3C, 8'h3C, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0};
        vecs[11] = '{1'b1, 1'b0, 4'b0000, 8'h3C, 8'h3C, 1'b0, 1'b1, 3'd0, 1'b0, 16'd0};
        vecs[12] = '{1'b0, 1'b0, 4'b0000, 8'h3C, 8'h3C, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0};

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            start    = vecs[i].start;
            abort    = vecs[i].abort;
            phase_en = vecs[i].en;
            idle_pat = vecs[i].idle;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_busy,
                       vecs[i].e_done, vecs[i].e_idx);
            if (vecs[i].chk_pass)
                check($sformatf("vec%0d_pass", i), 32'(pass_cnt), 32'(vecs[i].e_pass));
        end
        start = 1'b0; abort = 1'b0;

        // Basic two-phase run; config inputs scrambled mid-run must not matter.
        phase_en = 4'b0011; repeat_cnt = 16'd2; idle_pat = 8'h0F;
        set_phase(0, 32'd40, 8'h88); set_phase(1, 32'd20, 8'h80);
        set_phase(2, 32'd7, 8'h22);  set_phase(3, 32'd7, 8'h33);
        start = 1'b1;
        tick();
        start = 1'b0;
        bad = 0; first_bad = -1; busy_cycles = 0;
        for (int c = 1; c <= 125; c++) begin
            if (c <= 120) begin
                eb = 1'b1; ed = 1'b0;
                eo = (((c - 1) % 60) < 40) ? 8'h88 : 8'h80;
                ei = (((c - 1) % 60) < 40) ? 3'd0 : 3'd1;
            end else begin
                eb = 1'b0; ed = (c == 121); eo = 8'h0F; ei = 3'd0;
            end
            if (busy === 1'b1) busy_cycles++;
            if (signal_out !== eo || busy !== eb || done !== ed || phase_idx !== ei) begin
                bad++;
                if (first_bad < 0) first_bad = c;
            end
            if (c == 61)  check("basic_pass_mid", 32'(pass_cnt), 32'd1);
            if (c == 121) check("basic_pass_end", 32'(pass_cnt), 32'd2);
            if (c == 5) begin
                set_phase(0, 32'd3, 8'hEE); set_phase(1, 32'd3, 8'hDD);
                phase_en = 4'b1111; repeat_cnt = 16'd1;
            end
            if (c < 125) tick();
        end
        if (bad != 0) $display("basic run: first deviating cycle %0d", first_bad);
        check("basic_bad_cycles", 32'(bad), 32'd0);
        check("basic_busy_cycles", 32'(busy_cycles), 32'd120);

        // Infinite run then abort.
        phase_en = 4'b0110; repeat_cnt = 16'd0; idle_pat = 8'h0A;
        set_phase(1, 32'd2, 8'h61); set_phase(2, 32'd3, 8'h62);
        start = 1'b1;
        tick();
        start = 1'b0;
        bad = 0; first_bad = -1;
        for (int c = 1; c <= 1000; c++) begin
            eo = (((c - 1) % 5) < 2) ? 8'h61 : 8'h62;
            ei = (((c - 1) % 5) < 2) ? 3'd1 : 3'd2;
            if (signal_out !== eo || busy !== 1'b1 || done !== 1'b0 || phase_idx !== ei) begin
                bad++;
                if (first_bad < 0) first_bad = c;
            end
            if (c < 1000) tick();
        end
        if (bad != 0) $display("infinite run: first deviating cycle %0d", first_bad);
        check("inf_bad_cycles", 32'(bad), 32'd0);
        check("inf_pass", 32'(pass_cnt), 32'd199);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_outs("inf_abort", 8'h0A, 1'b0, 1'b0, 3'd0);
        tick();
        check("inf_abort_late_done", 32'(done), 32'd0);

        // Abort on the final cycle of the last pass beats completion.
        phase_en = 4'b0001; repeat_cnt = 16'd1; idle_pat = 8'h0B;
        set_phase(0, 32'd3, 8'h71);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_outs("lastab_c1", 8'h71, 1'b1, 1'b0, 3'd0);
        tick();
        tick();
        check_outs("lastab_c3", 8'h71, 1'b1, 1'b0, 3'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_outs("lastab_after", 8'h0B, 1'b0, 1'b0, 3'd0);
        tick();
        check("lastab_late_done", 32'(done), 32'd0);

        // Start while running is ignored.
        phase_en = 4'b0001; repeat_cnt = 16'd1; idle_pat = 8'h0C;
        set_phase(0, 32'd4, 8'h11);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; phase_en = 4'b0100; set_phase(2, 32'd1, 8'h99);
        tick();
        start = 1'b0;
        check_outs("rerun_c3", 8'h11, 1'b1, 1'b0, 3'd0);
        tick();
        check_outs("rerun_c4", 8'h11, 1'b1, 1'b0, 3'd0);
        tick();
        check_outs("rerun_fin", 8'h0C, 1'b0, 1'b1, 3'd0);
        tick();
        check_outs("rerun_after", 8'h0C, 1'b0, 1'b0, 3'd0);

        // Asynchronous reset mid-phase, then a fresh run from phase 0.
        phase_en = 4'b0011; repeat_cnt = 16'd1; idle_pat = 8'h0D;
        set_phase(0, 32'd40, 8'h88); set_phase(1, 32'd20, 8'h80);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        #2 rst_n = 1'b0;
        #1;
        check_outs("areset", 8'h00, 1'b0, 1'b0, 3'd0);
        check("areset_pass", 32'(pass_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_outs("rel_idle", 8'h0D, 1'b0, 1'b0, 3'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_outs("rel_c1", 8'h88, 1'b1, 1'b0, 3'd0);
        repeat (59) tick();
        check_outs("rel_c60", 8'h80, 1'b1, 1'b0, 3'd1);
        tick();
        check_outs("rel_fin", 8'h0D, 1'b0, 1'b1, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_sequencer.md
PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 SHALL have parameters (one per line: name, default, meaning):
  NUM_PHASES  4   number of programmable pulse phases (2..8)
  DUR_W       32  phase duration counter width
  CNT_W       16  repeat counter width
REQ-002 SHALL have ports (one per line: name  direction  width  meaning):
  clk_in       in   1               sole clock, all logic on rising edge
  rst_n_in     in   1               reset, asynchronous, active-low
  start        in   1               begin sequence; sampled only in IDLE
  abort        in   1               terminate sequence immediately
  phase_dur    in   NUM_PHASES*DUR_W  duration per phase, phase i at bits [i*DUR_W +: DUR_W]
  phase_pat    in   NUM_PHASES*8    8-bit output pattern per phase
  phase_en     in   NUM_PHASES      per-phase enable; disabled phases skipped
  repeat_cnt   in   CNT_W           full passes to run; 0 = run until abort
  idle_pat     in   8               pattern driven while not running
  signal_out   out  8               registered pulse pattern output
  busy         out  1               high while sequence runs
  done         out  1               one-cycle pulse on normal completion
  phase_idx    out  3               index of active phase (0 when idle)
  pass_cnt     out  CNT_W           completed passes in current run

Function
REQ-003 SHALL implement states IDLE, RUN, FIN; FIN lasts exactly one cycle, then IDLE.
REQ-004 In IDLE, signal_out SHALL equal idle_pat registered (one-cycle latency from idle_pat).
REQ-005 On edge k with start=1, abort=0, state IDLE, and phase_en nonzero: latch phase_dur, phase_pat, phase_en, repeat_cnt; enter RUN at lowest enabled phase; from edge k+1 busy=1, signal_out=that phase's pattern, pass_cnt=0.
REQ-006 Latched config SHALL be used for the whole run; input changes during RUN have no effect.
REQ-007 start with phase_en=0 SHALL go to FIN (done=1 one cycle, busy stays 0, signal_out stays idle_pat).
REQ-008 start while busy SHALL be ignored.
REQ-009 Each phase SHALL hold signal_out for exactly max(dur,1) cycles; dur=0 treated as 1.
REQ-010 At phase end SHALL advance to next higher enabled phase, skipping disabled ones, with no gap cycle.
REQ-011 After the highest enabled phase, pass_cnt SHALL increment (saturating at all-ones) and sequence SHALL wrap to lowest enabled phase.
REQ-012 When incremented pass_cnt equals repeat_cnt (nonzero), SHALL enter FIN instead of wrapping: next cycle signal_out=idle_pat, busy=0, done=1.
REQ-013 repeat_cnt=0 SHALL loop indefinitely; pass_cnt saturates, never wraps.
REQ-014 abort=1 during RUN SHALL on the next edge force IDLE: busy=0, signal_out=idle_pat, done stays 0.
REQ-015 abort and natural completion on same edge: abort wins, done not asserted.
REQ-016 start and abort together in IDLE: start ignored.
REQ-017 Duration timer SHALL be DUR_W bits, compare ">= dur-1", never overflow.
REQ-018 phase_idx SHALL track the phase currently on signal_out, cycle-aligned with it.

Reset
REQ-019 rst_n_in low SHALL asynchronously force IDLE, signal_out=8'h00, busy=0, done=0, phase_idx=0, pass_cnt=0, timer=0, regardless of state.
REQ-020 Reset release SHALL take effect on the first rising clk_in with rst_n_in high; signal_out follows idle_pat from that edge.

Verification
REQ-021 Basic: en=4'b0011, dur={_,_,20,40}, pat={_,_,80,88}, repeat=2, start -> 88h for 40 cycles, 80h for 20, 88h 40, 80h 20, then done=1 one cycle, busy low, total busy 120 cycles.
REQ-022 Skip/zero: en=4'b1010, dur1=0, dur3=5, repeat=1 -> phase1 one cycle, phase3 five cycles, done; phase_idx 1 then 3.
REQ-023 Infinite+abort: repeat=0, run 1000 cycles, abort -> next cycle signal_out=idle_pat, busy=0, no done pulse.
REQ-024 Edge collisions: abort on final cycle of last pass -> no done; start during RUN -> no restart; start with en=0 -> done only.
REQ-025 Reset mid-phase: drop rst_n_in asynchronously between edges -> outputs zero immediately; after release, new start runs full sequence from phase 0.
REQ-026 Config isolation: change phase_dur/phase_pat during RUN -> output timing and patterns unchanged until next start.
